inverter_vtc_sweeper: RTL

- Clocked controller that sequences a DC voltage-transfer-curve (VTC) sweep of the RNM inverter.
- Steps the inverter input from VSTART to VSTOP in VSTEP increments and waits a settle interval at each point.
- Samples the inverter output at each point and reports the switching threshold VM, found by linear interpolation at the VDD/2 crossing.
- Sits in the testbench/characterisation layer: drives the inverter's vin and observes its vout.

---
 rtl/inv_rnm_pkg.sv | 18 +
 rtl/vtc_cross_interp.sv | 25 ++
 rtl/inverter_vtc_sweeper.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/inv_rnm_pkg.sv
// Shared types and constants for the RNM inverter characterisation slice.
// The optional gain tracking in inverter_vtc_sweeper is enabled by defining VTC_GAIN_EN.
package inv_rnm_pkg;

    // Real-valued analog node type used between the RNM blocks.
    typedef real realnet;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} vtc_state_t;

    localparam real VDD_DEFAULT = 1.8;

    // Sweep voltage for an index. It is derived from the index rather than
    // accumulated, so rounding error cannot build up across a sweep.
    function automatic real vin_at(input real vstart, input real vstep, input int idx);
        return vstart + real'(idx) * vstep;
    endfunction

endpackage

// File: rtl/vtc_cross_interp.sv
// Detects a falling VDD/2 crossing between two adjacent VTC samples and
// linearly interpolates the input voltage at which it occurred.
module vtc_cross_interp (
    input  real  prev_vout,
    input  real  cur,
    input  real  vin_prev,
    input  real  vdd,
    input  real  vstep,
    output logic hit,
    output real  vm_est
);

    real half;

    always_comb begin
        half   = vdd / 2.0;
        hit    = (prev_vout >= half) && (cur < half);
        vm_est = 0.0;
        // prev_vout > cur whenever hit is set, so the divisor is never zero.
        if (hit) begin
            vm_est = vin_prev + (prev_vout - half) / (prev_vout - cur) * vstep;
        end
    end

endmodule

// File: rtl/inverter_vtc_sweeper.sv
// DC VTC sweep controller for the RNM inverter: steps vin, settles, samples
// vout and reports the VDD/2 switching threshold. Optional macro: VTC_GAIN_EN.
module inverter_vtc_sweeper
    import inv_rnm_pkg::*;
#(
    parameter real VDD        = VDD_DEFAULT,
    parameter real VSTART     = 0.0,
    parameter real VSTOP      = 1.8,
    parameter real VSTEP      = 0.01,
    parameter int  SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  real         vout_sense,
    output real         vin_drive,
    output logic        busy,
    output logic        done,
    output logic        crossed,
    output real         vm,
    output logic [15:0] step_idx,
    output real         gain_max
);

    localparam int          NSTEPS      = $rtoi((VSTOP - VSTART) / VSTEP + 0.5);
    localparam logic [15:0] LAST_IDX    = 16'(NSTEPS);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

    vtc_state_t  state_reg, state_next;
    logic [15:0] step_reg, step_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        crossed_reg, crossed_next;
    real         vm_reg, vm_next;
    real         prev_reg, prev_next;

    real  vin_prev;
    logic hit;
    real  vm_est;
    logic sweep_start;
    logic sample_fire;

    assign vin_prev    = vin_at(VSTART, VSTEP, int'(step_reg) - 1);
    assign sweep_start = (state_reg == IDLE) && start && !abort;
    assign sample_fire = (state_reg == SAMPLE) && !abort;

    vtc_cross_interp u_cross (
        .prev_vout (prev_reg),
        .cur       (vout_sense),
        .vin_prev  (vin_prev),
        .vdd       (VDD),
        .vstep     (VSTEP),
        .hit       (hit),
        .vm_est    (vm_est)
    );

    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        cnt_next     = cnt_reg;
        crossed_next = crossed_reg;
        vm_next      = vm_reg;
        prev_next    = prev_reg;
        case (state_reg)
            IDLE: begin
                if (sweep_start) begin
                    state_next   = SETTLE;
                    step_next    = '0;
                    cnt_next     = SETTLE_LOAD;
                    crossed_next = 1'b0;
                    vm_next      = 0.0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (cnt_reg == '0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else begin
                    prev_next = vout_sense;
                    // Only the first falling crossing of a sweep is kept.
                    if ((step_reg != '0) && !crossed_reg && hit) begin
                        crossed_next = 1'b1;
                        vm_next      = vm_est;
                    end
                    if (step_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETTLE;
                        step_next  = step_reg + 16'd1;
                        cnt_next   = SETTLE_LOAD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            step_reg    <= '0;
            cnt_reg     <= '0;
            crossed_reg <= 1'b0;
            vm_reg      <= 0.0;
            prev_reg    <= 0.0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            cnt_reg     <= cnt_next;
            crossed_reg <= crossed_next;
            vm_reg      <= vm_next;
            prev_reg    <= prev_next;
        end
    end

`ifdef VTC_GAIN_EN
    real gain_reg, gain_next, slope_abs;

    always_comb begin
        slope_abs = (prev_reg - vout_sense) / VSTEP;
        if (slope_abs < 0.0) begin
            slope_abs = -slope_abs;
        end
        gain_next = gain_reg;
        if (sweep_start) begin
            gain_next = 0.0;
        end else if (sample_fire && (step_reg != '0) && (slope_abs > gain_reg)) begin
            gain_next = slope_abs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_reg <= 0.0;
        end else begin
            gain_reg <= gain_next;
        end
    end

    assign gain_max = gain_reg;
`else
    logic unused_sample_fire;
    assign unused_sample_fire = sample_fire;
    assign gain_max = 0.0;
`endif

    assign vin_drive = vin_at(VSTART, VSTEP, int'(step_reg));
    assign busy      = (state_reg == SETTLE) || (state_reg == SAMPLE);
    assign done      = (state_reg == DONE);
    assign crossed   = crossed_reg;
    assign vm        = vm_reg;
    assign step_idx  = step_reg;

endmodule
